// File: rtl/feature_extractor_pipe.sv
// One frame of raster pixels goes through a 3x3 signed conv, then an activation, then an optional
// 2x2/stride-2 max-pool. The pipeline moves only on accepted pixels and the frame ends with a done pulse.
module feature_extractor_pipe #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int PIX_W   = 8,
  parameter int COEF_W  = 8,
  parameter int ACC_W   = 22,
  parameter int POOL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pixel_valid,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              coef_wr_en,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic [1:0]        act_mode,
  output logic              busy,
  output logic [ACC_W-1:0]  result_out,
  output logic              result_valid,
  output logic              done,
  output logic              frame_err,
  output logic [1:0]        fsm_state
);
  localparam int OW = IMG_W - 2;
  localparam int OH = IMG_H - 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int JW = $clog2(OW);
  localparam int IW = $clog2(OH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_n;

  // Handshake: pixel_valid qualifies pixel_in and is taken only in RUN, with no backpressure.
  // result_valid is a one-cycle strobe with no ready; the downstream must take every result.
  logic                     accept;
  logic                     frame_start;
  logic                     last_pix;
  logic                     upstream_v;
  logic [RW-1:0]            row;
  logic [CW-1:0]            col;
  logic [1:0]               mode_q;
  logic signed [COEF_W-1:0] coef [9];

  assign accept      = (state == RUN) && pixel_valid;
  assign frame_start = (state == IDLE) && start;
  assign last_pix    = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (accept && last_pix) state_n = FLUSH;
      // The last result is the one that leaves the pipeline empty behind it.
      FLUSH:   if (result_valid && !upstream_v) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == RUN) || (state == FLUSH);
  assign done      = (state == DONE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row       <= '0;
      col       <= '0;
      mode_q    <= '0;
      frame_err <= 1'b0;
      for (int k = 0; k < 9; k++) coef[k] <= '0;
    end else begin
      if ((state == IDLE) && coef_wr_en && (coef_addr <= 4'd8))
        coef[coef_addr] <= coef_data;
      if (frame_start) begin
        row       <= '0;
        col       <= '0;
        mode_q    <= act_mode;
        frame_err <= 1'b0;
      end else begin
        if (accept) begin
          if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        if ((start && (state != IDLE)) || (pixel_valid && (state == FLUSH)))
          frame_err <= 1'b1;
      end
    end
  end

  // lb_a holds the previous row and lb_b the row before it, both indexed by column.
  logic [PIX_W-1:0] lb_a [IMG_W];
  logic [PIX_W-1:0] lb_b [IMG_W];
  logic [PIX_W-1:0] win  [3][3];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_b[col] <= lb_a[col];
      lb_a[col] <= pixel_in;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb_b[col];
      win[1][2] <= lb_a[col];
      win[2][2] <= pixel_in;
    end
  end

  logic                    win_v, mac_v, act_v;
  logic signed [ACC_W-1:0] mac_n, mac_q, act_n, act_q;

  always_comb begin
    mac_n = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        mac_n = mac_n + ACC_W'(signed'({1'b0, win[r][c]})) * ACC_W'(coef[3*r+c]);
      end
    end
  end

  always_comb begin
    act_n = mac_q;
    if (mac_q[ACC_W-1]) begin
      case (mode_q)
        2'd0:    act_n = mac_q;
        2'd2:    act_n = mac_q >>> 3;
        default: act_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_v <= 1'b0;
      mac_v <= 1'b0;
      act_v <= 1'b0;
      mac_q <= '0;
      act_q <= '0;
    end else begin
      win_v <= accept && (row >= RW'(2)) && (col >= CW'(2));
      mac_v <= win_v;
      act_v <= mac_v;
      if (win_v) mac_q <= mac_n;
      if (mac_v) act_q <= act_n;
    end
  end

  generate
    if (POOL_EN != 0) begin : g_pool
      logic [JW-1:0]           pool_j;
      logic [IW-1:0]           pool_i;
      logic signed [ACC_W-1:0] hold_q, pair, buf_rd, res_q;
      logic signed [ACC_W-1:0] row_buf [OW/2];
      logic                    res_v;

      assign pair   = (act_q > hold_q) ? act_q : hold_q;
      assign buf_rd = row_buf[pool_j >> 1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pool_j <= '0;
          pool_i <= '0;
          hold_q <= '0;
          res_q  <= '0;
          res_v  <= 1'b0;
        end else begin
          res_v <= 1'b0;
          if (frame_start) begin
            pool_j <= '0;
            pool_i <= '0;
          end else if (act_v) begin
            if (pool_j == JW'(OW - 1)) begin
              pool_j <= '0;
              pool_i <= pool_i + 1'b1;
            end else begin
              pool_j <= pool_j + 1'b1;
            end
            if (!pool_j[0]) begin
              hold_q <= act_q;
            end else if (pool_i[0]) begin
              res_q <= (buf_rd > pair) ? buf_rd : pair;
              res_v <= 1'b1;
            end
          end
        end
      end

      // Even conv rows park their pair maxima here until the odd row below arrives.
      always_ff @(posedge clk) begin
        if (act_v && pool_j[0] && !pool_i[0]) row_buf[pool_j >> 1] <= pair;
      end

      assign result_out   = res_q;
      assign result_valid = res_v;
      assign upstream_v   = win_v | mac_v | act_v;
    end else begin : g_nopool
      assign result_out   = act_q;
      assign result_valid = act_v;
      assign upstream_v   = win_v | mac_v;
    end
  endgenerate

endmodule

// File: tb/tb_feature_extractor_pipe.sv
// Bench for feature_extractor_pipe: one pooled and one unpooled instance share stimulus on a 6x6 frame.
// Results are checked against a plain-arithmetic model, a table of hand-derived values and corner sequences.
module tb_feature_extractor_pipe;
  localparam int W   = 6;
  localparam int H   = 6;
  localparam int PW  = 8;
  localparam int CWD = 8;
  localparam int AW  = 22;
  localparam int OW  = W - 2;
  localparam int OH  = H - 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           pixel_valid = 1'b0;
  logic [PW-1:0]  pixel_in = '0;
  logic           coef_wr_en = 1'b0;
  logic [3:0]     coef_addr = '0;
  logic [CWD-1:0] coef_data = '0;
  logic [1:0]     act_mode = '0;

  logic          busy_p, rv_p, done_p, err_p, busy_n, rv_n, done_n, err_n;
  logic [AW-1:0] res_p, res_n;
  logic [1:0]    st_p, st_n;

  feature_extractor_pipe #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .COEF_W(CWD), .ACC_W(AW), .POOL_EN(1)) dut_p (
    .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data), .act_mode(act_mode),
    .busy(busy_p), .result_out(res_p), .result_valid(rv_p), .done(done_p), .frame_err(err_p),
    .fsm_state(st_p));

  feature_extractor_pipe #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .COEF_W(CWD), .ACC_W(AW), .POOL_EN(0)) dut_n (
    .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data), .act_mode(act_mode),
    .busy(busy_n), .result_out(res_n), .result_valid(rv_n), .done(done_n), .frame_err(err_n),
    .fsm_state(st_n));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] exp_p_q[$], exp_n_q[$];
  int            exp_p_cyc[$], exp_n_cyc[$];
  logic [AW-1:0] got_p_q[$], got_n_q[$];
  int            got_p_cyc[$], got_n_cyc[$];
  logic          got_p_busy[$];
  int            done_p_cyc[$], done_n_cyc[$];
  logic          done_p_busy[$], done_n_busy[$];

  int pix[H][W];
  int acc_cyc[H][W];
  int coef_m[9];
  int mode_m;

  always @(negedge clk) begin
    if (rst) begin
      if (rv_p) begin got_p_q.push_back(res_p); got_p_cyc.push_back(cyc); got_p_busy.push_back(busy_p); end
      if (rv_n) begin got_n_q.push_back(res_n); got_n_cyc.push_back(cyc); end
      if (done_p) begin done_p_cyc.push_back(cyc); done_p_busy.push_back(busy_p); end
      if (done_n) begin done_n_cyc.push_back(cyc); done_n_busy.push_back(busy_n); end
    end
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_got();
    got_p_q.delete(); got_n_q.delete(); got_p_cyc.delete(); got_n_cyc.delete(); got_p_busy.delete();
    done_p_cyc.delete(); done_n_cyc.delete(); done_p_busy.delete(); done_n_busy.delete();
  endtask

  // ---------------- reference model ----------------
  function automatic longint act_fn(input longint s, input int m);
    if (s >= 0) return s;
    case (m)
      0:       return s;
      2:       return -((-s + 7) / 8);   // floor(s / 8)
      default: return 0;
    endcase
  endfunction

  task automatic build_expect();
    longint a[OH][OW];
    longint s, m;
    exp_p_q.delete(); exp_n_q.delete(); exp_p_cyc.delete(); exp_n_cyc.delete();
    for (int i = 0; i < OH; i++) begin
      for (int j = 0; j < OW; j++) begin
        s = 0;
        for (int u = 0; u < 3; u++)
          for (int v = 0; v < 3; v++)
            s += longint'(pix[i+u][j+v]) * longint'(coef_m[3*u+v]);
        a[i][j] = act_fn(s, mode_m);
        exp_n_q.push_back(AW'(a[i][j]));
        exp_n_cyc.push_back(acc_cyc[i+2][j+2] + 3);
      end
    end
    for (int bi = 0; bi < OH/2; bi++) begin
      for (int bj = 0; bj < OW/2; bj++) begin
        m = a[2*bi][2*bj];
        for (int u = 0; u < 2; u++)
          for (int v = 0; v < 2; v++)
            if (a[2*bi+u][2*bj+v] > m) m = a[2*bi+u][2*bj+v];
        exp_p_q.push_back(AW'(m));
        exp_p_cyc.push_back(acc_cyc[2*bi+3][2*bj+3] + 4);
      end
    end
  endtask

  task automatic compare_frame(input string tag);
    int n;
    build_expect();
    check({tag, " n_count"}, got_n_q.size(), exp_n_q.size());
    check({tag, " p_count"}, got_p_q.size(), exp_p_q.size());
    n = (got_n_q.size() < exp_n_q.size()) ? got_n_q.size() : exp_n_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s n_val[%0d]", tag, k), $signed(got_n_q[k]), $signed(exp_n_q[k]));
      check($sformatf("%s n_lat[%0d]", tag, k), got_n_cyc[k], exp_n_cyc[k]);
    end
    n = (got_p_q.size() < exp_p_q.size()) ? got_p_q.size() : exp_p_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s p_val[%0d]", tag, k), $signed(got_p_q[k]), $signed(exp_p_q[k]));
      check($sformatf("%s p_lat[%0d]", tag, k), got_p_cyc[k], exp_p_cyc[k]);
    end
    check({tag, " p_done_count"}, done_p_cyc.size(), 1);
    check({tag, " n_done_count"}, done_n_cyc.size(), 1);
    if (done_p_cyc.size() == 1 && got_p_q.size() > 0) begin
      check({tag, " p_done_after_last"}, done_p_cyc[0], got_p_cyc[got_p_cyc.size()-1] + 1);
      check({tag, " p_busy_at_last"}, got_p_busy[got_p_busy.size()-1], 1);
      check({tag, " p_busy_at_done"}, done_p_busy[0], 0);
    end
    if (done_n_cyc.size() == 1 && got_n_q.size() > 0) begin
      check({tag, " n_done_after_last"}, done_n_cyc[0], got_n_cyc[got_n_cyc.size()-1] + 1);
      check({tag, " n_busy_at_done"}, done_n_busy[0], 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_pattern(input int cp, input int pp);
    for (int k = 0; k < 9; k++) begin
      case (cp)
        0:       coef_m[k] = 1;
        1:       coef_m[k] = (k == 4) ? 1 : 0;
        2:       coef_m[k] = (k == 4) ? -1 : 0;
        3:       coef_m[k] = int'($urandom_range(255)) - 128;
        default: coef_m[k] = 0;
      endcase
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pp)
          0:       pix[r][c] = 1;
          1:       pix[r][c] = W * r + c;
          default: pix[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic run_frame(input string tag, input int gap_pct, input bit load,
                           input bit inj_start, input bit inj_flush, input bit inj_coef);
    clear_got();
    if (load) begin
      coef_wr_en = 1'b1;
      coef_addr  = 4'($urandom_range(15, 9));
      coef_data  = CWD'($urandom);
      tick();
      for (int k = 0; k < 9; k++) begin
        coef_addr = 4'(k);
        coef_data = CWD'(coef_m[k]);
        if (k == 8) begin start = 1'b1; act_mode = 2'(mode_m); end
        tick();
      end
    end else begin
      start    = 1'b1;
      act_mode = 2'(mode_m);
      tick();
    end
    coef_wr_en = 1'b0;
    start      = 1'b0;
    act_mode   = 2'($urandom);
    check({tag, " p_err_cleared"}, err_p, 0);
    check({tag, " n_err_cleared"}, err_n, 0);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          pixel_valid = 1'b0;
          pixel_in    = PW'($urandom);
          tick();
        end
        pixel_valid   = 1'b1;
        pixel_in      = PW'(pix[r][c]);
        acc_cyc[r][c] = cyc;
        if (inj_start && (r * W + c == 10)) start = 1'b1;
        if (inj_coef && (r * W + c == 5)) begin
          coef_wr_en = 1'b1;
          coef_addr  = 4'($urandom_range(8));
          coef_data  = CWD'($urandom_range(127, 50));
        end
        tick();
        start      = 1'b0;
        coef_wr_en = 1'b0;
      end
    end
    pixel_valid = 1'b0;
    if (inj_flush) begin
      pixel_valid = 1'b1;
      pixel_in    = PW'($urandom);
      tick();
      pixel_valid = 1'b0;
    end
    for (int t = 0; t < 100 && (done_p_cyc.size() == 0 || done_n_cyc.size() == 0); t++) tick();
    repeat (3) tick();
    compare_frame(tag);
    check({tag, " p_frame_err"}, err_p, inj_start || inj_flush);
    check({tag, " n_frame_err"}, err_n, inj_start || inj_flush);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " p_busy"}, busy_p, 0);
    check({tag, " p_result"}, res_p, 0);
    check({tag, " p_valid"}, rv_p, 0);
    check({tag, " p_done"}, done_p, 0);
    check({tag, " p_err"}, err_p, 0);
    check({tag, " n_busy"}, busy_n, 0);
    check({tag, " n_result"}, res_n, 0);
    check({tag, " n_valid"}, rv_n, 0);
    check({tag, " n_done"}, done_n, 0);
    check({tag, " n_err"}, err_n, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int coef_pat;
    int pix_pat;
    int mode;
    int gap;
    int n_first;
    int n_last;
    int p_first;
    int p_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 1,  0,  9,   9,  9,   9};
    vecs[1] = '{1, 1, 1,  0,  7,  28, 14,  28};
    vecs[2] = '{2, 1, 0,  0, -7, -28, -7, -21};
    vecs[3] = '{2, 1, 1,  0,  0,   0,  0,   0};
    vecs[4] = '{2, 1, 2,  0, -1,  -4, -1,  -3};
    vecs[5] = '{1, 1, 1, 50,  7,  28, 14,  28};
    vecs[6] = '{2, 1, 3,  0,  0,   0,  0,   0};

    rst = 1'b0;
    repeat (3) tick();
    check_quiet("reset");
    rst = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      set_pattern(vecs[v].coef_pat, vecs[v].pix_pat);
      mode_m = vecs[v].mode;
      run_frame($sformatf("vec%0d", v), vecs[v].gap, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d tbl_n_count", v), got_n_q.size(), OW * OH);
      check($sformatf("vec%0d tbl_p_count", v), got_p_q.size(), (OW/2) * (OH/2));
      if (got_n_q.size() == OW * OH) begin
        check($sformatf("vec%0d tbl_n_first", v), $signed(got_n_q[0]), vecs[v].n_first);
        check($sformatf("vec%0d tbl_n_last", v), $signed(got_n_q[OW*OH-1]), vecs[v].n_last);
      end
      if (got_p_q.size() == (OW/2) * (OH/2)) begin
        check($sformatf("vec%0d tbl_p_first", v), $signed(got_p_q[0]), vecs[v].p_first);
        check($sformatf("vec%0d tbl_p_last", v), $signed(got_p_q[(OW/2)*(OH/2)-1]), vecs[v].p_last);
      end
    end

    // Protocol errors: start during RUN and a pixel during FLUSH; results must be unaffected.
    set_pattern(1, 1);
    mode_m = 1;
    run_frame("err_inject", 0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame("err_clear", 20, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 6; f++) begin
      set_pattern(3, 2);
      mode_m = int'($urandom_range(3));
      run_frame($sformatf("rand%0d", f), int'($urandom_range(70)), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Reset after 20 pixels of a frame.
    set_pattern(0, 0);
    mode_m = 1;
    clear_got();
    for (int k = 0; k < 9; k++) begin
      coef_wr_en = 1'b1;
      coef_addr  = 4'(k);
      coef_data  = CWD'(coef_m[k]);
      if (k == 8) begin start = 1'b1; act_mode = 2'(mode_m); end
      tick();
    end
    coef_wr_en = 1'b0;
    start      = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pixel_valid = 1'b1;
      pixel_in    = 8'd1;
      tick();
    end
    pixel_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_quiet("midreset");
    repeat (2) tick();
    clear_got();
    rst = 1'b1;
    repeat (15) tick();
    check("midreset p_no_results", got_p_q.size(), 0);
    check("midreset n_no_results", got_n_q.size(), 0);
    check("midreset p_no_done", done_p_cyc.size(), 0);
    check("midreset n_no_done", done_n_cyc.size(), 0);

    // Coefficients come back from reset as zero.
    set_pattern(4, 2);
    mode_m = 0;
    run_frame("coef_reset", 10, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full frame after reset, with a coefficient write attempted mid-frame.
    set_pattern(0, 0);
    mode_m = 1;
    run_frame("post_reset", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    if (got_p_q.size() == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("post_reset p_nine[%0d]", k), $signed(got_p_q[k]), 9);
    end else begin
      check("post_reset p_nine_count", got_p_q.size(), 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
